// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// FSM state encoding, port-owner enumeration and default widths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between the fetch port and the data port.
// Default build: fixed data priority, with a saturating starvation counter
// that forces a fetch win after STARVE_MAX consecutive fetch losses.
// With MEM_ARB_RR_EN defined: round-robin on a last-winner flag instead.
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
)
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   sel_en,
  input  logic   if_req,
  input  logic   dm_req,
  output owner_e win
);

`ifdef MEM_ARB_RR_EN

  owner_e last_win;

  // When both ports request, the side that did not win last time gets the port.
  always_comb begin
    win = OWN_DM;
    if (if_req && dm_req) begin
      win = (last_win == OWN_DM) ? OWN_IF : OWN_DM;
    end else if (if_req) begin
      win = OWN_IF;
    end
  end

  // Remember the winner of every arbitration; reset as if data won last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_win <= OWN_DM;
    end else if (sel_en) begin
      last_win <= win;
    end
  end

`else

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // Data wins by default; a starved fetch request overrides it.
  always_comb begin
    win = OWN_DM;
    if (if_req && (!dm_req || starved)) begin
      win = OWN_IF;
    end
  end

  // Count fetch losses at each arbitration, clear on a fetch win, saturate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (sel_en) begin
      if (win == OWN_IF) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch stage and the memory stage
// with at most one transaction outstanding (IDLE -> REQ -> RESP).
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
)
(
  input  logic                i_clk,
  input  logic                i_rstn,
  // fetch side
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  // data side
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_be,
  output logic                o_dm_gnt,
  output logic                o_dm_rvalid,
  output logic [DATA_W-1:0]   o_dm_rdata,
  // memory side
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  // pipeline holds
  output logic                o_stall_if,
  output logic                o_stall_mem
);

  localparam int BE_W = DATA_W / 8;

  state_e              state;
  owner_e              owner;
  owner_e              win;
  logic                sel_en;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                cmd_we;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [BE_W-1:0]     cmd_be;
  logic                gnt_if_q;
  logic                gnt_dm_q;
  logic                resp_hit;

  assign sel_en = (state == ST_IDLE) && (i_if_req || i_dm_req);

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .clk    (i_clk),
    .rstn   (i_rstn),
    .sel_en (sel_en),
    .if_req (i_if_req),
    .dm_req (i_dm_req),
    .win    (win)
  );

  // Transaction FSM: latch the winner's command, hold it until granted,
  // then wait for the read data / write acknowledge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      cmd_addr  <= '0;
      cmd_we    <= 1'b0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
      gnt_if_q  <= 1'b0;
      gnt_dm_q  <= 1'b0;
    end else begin
      gnt_if_q <= 1'b0;
      gnt_dm_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_en) begin
            owner <= win;
            state <= ST_REQ;
            if (win == OWN_DM) begin
              cmd_addr  <= i_dm_addr;
              cmd_we    <= i_dm_we;
              cmd_wdata <= i_dm_wdata;
              cmd_be    <= i_dm_be;
            end else begin
              cmd_addr  <= i_if_addr;
              cmd_we    <= 1'b0;
              cmd_wdata <= '0;
              cmd_be    <= '1;
            end
          end
        end
        ST_REQ: begin
          // A same-cycle rvalid is not a response to this request yet.
          if (i_mem_gnt) begin
            state    <= ST_RESP;
            gnt_if_q <= (owner == OWN_IF);
            gnt_dm_q <= (owner == OWN_DM);
          end
        end
        ST_RESP: begin
          if (i_mem_rvalid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_req   = (state == ST_REQ);
  assign o_mem_we    = (state == ST_REQ) && cmd_we;
  assign o_mem_addr  = cmd_addr;
  assign o_mem_wdata = cmd_wdata;
  assign o_mem_be    = cmd_be;

  assign o_if_gnt    = gnt_if_q;
  assign o_dm_gnt    = gnt_dm_q;

  // Responses are steered straight through to the owner in the rvalid cycle.
  assign resp_hit    = (state == ST_RESP) && i_mem_rvalid;
  assign o_if_rvalid = resp_hit && (owner == OWN_IF);
  assign o_dm_rvalid = resp_hit && (owner == OWN_DM);
  assign o_if_rdata  = i_mem_rdata;
  assign o_dm_rdata  = i_mem_rdata;

  assign o_stall_if  = i_if_req && !o_if_rvalid;
  assign o_stall_mem = i_dm_req && !o_dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a cycle-stepped memory responder.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          i_clk;
  logic          i_rstn;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_dm_req;
  logic          i_dm_we;
  logic [AW-1:0] i_dm_addr;
  logic [DW-1:0] i_dm_wdata;
  logic [BW-1:0] i_dm_be;
  logic          o_dm_gnt;
  logic          o_dm_rvalid;
  logic [DW-1:0] o_dm_rdata;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [BW-1:0] o_mem_be;
  logic          i_mem_gnt;
  logic          i_mem_rvalid;
  logic [DW-1:0] i_mem_rdata;
  logic          o_stall_if;
  logic          o_stall_mem;

  int total = 0;
  int bad   = 0;

  // observations collected by serve()
  int            s_timeout, s_k, s_stable;
  int            s_gnt_if, s_gnt_dm, s_rv_if, s_rv_dm, s_gnt_at, s_rv_at;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [BW-1:0] s_be;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_stall_if_rv, s_stall_mem_rv;

  mem_port_arbiter dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be), .o_dm_gnt(o_dm_gnt),
    .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // read contents of the modelled memory
  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic tally();
    if (o_if_gnt === 1'b1)    begin s_gnt_if++; s_gnt_at = s_k; end
    if (o_dm_gnt === 1'b1)    begin s_gnt_dm++; s_gnt_at = s_k; end
    if (o_if_rvalid === 1'b1) begin s_rv_if++;  s_rv_at = s_k; s_rdata = o_if_rdata; end
    if (o_dm_rvalid === 1'b1) begin s_rv_dm++;  s_rv_at = s_k; s_rdata = o_dm_rdata; end
    if (o_mem_req === 1'b1 && (o_mem_addr !== s_addr || o_mem_we !== s_we ||
        o_mem_be !== s_be || o_mem_wdata !== s_wdata)) s_stable = 0;
    s_k++;
  endtask

  // Memory responder: grant after gd wait cycles, respond rd cycles after grant.
  task automatic serve(input int gd, input int rd, input bit rv_with_gnt, input bit drop_req);
    int n;
    s_timeout = 0; s_k = 0; s_stable = 1;
    s_gnt_if = 0; s_gnt_dm = 0; s_rv_if = 0; s_rv_dm = 0;
    s_gnt_at = -1; s_rv_at = -1; s_rdata = '0;
    n = 0;
    while (o_mem_req !== 1'b1) begin
      if (n == 30) begin s_timeout = 1; return; end
      step(); n++;
    end
    s_addr = o_mem_addr; s_we = o_mem_we; s_be = o_mem_be; s_wdata = o_mem_wdata;
    if (drop_req) begin i_if_req = 1'b0; i_dm_req = 1'b0; end
    for (int w = 0; w < gd; w++) begin
      tally(); step();
      if (o_mem_req !== 1'b1) s_stable = 0;
    end
    i_mem_gnt = 1'b1;
    if (rv_with_gnt) begin i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0_0000; end
    #1; tally();
    step(); i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; #1;
    for (int w = 0; w < rd; w++) begin tally(); step(); end
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = s_we ? 32'hFFFF_FFFF : model_rdata(s_addr);
    #1;
    s_stall_if_rv = o_stall_if; s_stall_mem_rv = o_stall_mem;
    tally();
    step(); i_mem_rvalid = 1'b0; #1; tally();
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    step(); step();
    i_rstn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    i_if_req = 1'b1; i_dm_req = 1'b1; i_dm_we = 1'b1; i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1;
    i_if_addr = 32'h55; i_dm_addr = 32'h66; i_dm_wdata = 32'h77; i_dm_be = 4'hF;
    step(); step();
    total++; if ({o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_mem_req, o_mem_we} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_mem_req, o_mem_we}); end
    total++; if (o_mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", o_mem_addr); end
    total++; if (o_mem_be !== 4'h0) begin bad++; $display("FAIL reset_be: got %h want 0", o_mem_be); end
    i_if_req = 1'b0; i_dm_req = 1'b0; i_dm_we = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_rstn = 1'b1;
    step();
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL post_reset_req: got %b want 0", o_mem_req); end
  endtask

  task automatic test_fetch_only();
    i_if_req = 1'b1; i_if_addr = 32'h100;
    #1;
    total++; if (o_stall_if !== 1'b1) begin bad++; $display("FAIL fo_stall_pre: got %b want 1", o_stall_if); end
    serve(0, 0, 1'b0, 1'b0);
    i_if_req = 1'b0;
    total++; if (s_timeout != 0) begin bad++; $display("FAIL fo_timeout: no o_mem_req"); end
    total++; if (s_addr !== 32'h100) begin bad++; $display("FAIL fo_addr: got %h want 100", s_addr); end
    total++; if (s_be !== 4'hF || s_we !== 1'b0) begin bad++; $display("FAIL fo_be_we: got be=%h we=%b want be=f we=0", s_be, s_we); end
    total++; if (s_gnt_if != 1 || s_gnt_dm != 0 || s_gnt_at != 1) begin bad++;
      $display("FAIL fo_gnt: got if=%0d dm=%0d at=%0d want 1 0 1", s_gnt_if, s_gnt_dm, s_gnt_at); end
    total++; if (s_rv_if != 1 || s_rv_dm != 0 || s_rv_at != 1) begin bad++;
      $display("FAIL fo_rvalid: got if=%0d dm=%0d at=%0d want 1 0 1", s_rv_if, s_rv_dm, s_rv_at); end
    total++; if (s_rdata !== 32'h0000_0013) begin bad++; $display("FAIL fo_rdata: got %h want 00000013", s_rdata); end
    total++; if (s_stall_if_rv !== 1'b0) begin bad++; $display("FAIL fo_stall_rv: got %b want 0", s_stall_if_rv); end
  endtask

  task automatic test_simultaneous();
    i_if_req = 1'b1; i_if_addr = 32'h104;
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h2000; i_dm_wdata = 32'hDEAD_BEEF; i_dm_be = 4'h3;
    serve(0, 0, 1'b0, 1'b0);
    i_dm_req = 1'b0; i_dm_we = 1'b0;
    total++; if (s_addr !== 32'h2000 || s_we !== 1'b1 || s_be !== 4'h3 || s_wdata !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL sim_dm_cmd: got a=%h we=%b be=%h d=%h want 2000 1 3 deadbeef", s_addr, s_we, s_be, s_wdata); end
    total++; if (s_rv_dm != 1 || s_rv_if != 0 || s_gnt_dm != 1) begin bad++;
      $display("FAIL sim_dm_resp: got rv_dm=%0d rv_if=%0d gnt_dm=%0d want 1 0 1", s_rv_dm, s_rv_if, s_gnt_dm); end
    total++; if (s_stall_if_rv !== 1'b1 || s_stall_mem_rv !== 1'b0) begin bad++;
      $display("FAIL sim_stalls: got if=%b mem=%b want 1 0", s_stall_if_rv, s_stall_mem_rv); end
    serve(0, 0, 1'b0, 1'b0);
    i_if_req = 1'b0;
    total++; if (s_addr !== 32'h104 || s_we !== 1'b0 || s_be !== 4'hF) begin bad++;
      $display("FAIL sim_if_cmd: got a=%h we=%b be=%h want 104 0 f", s_addr, s_we, s_be); end
    total++; if (s_rv_if != 1 || s_rv_dm != 0 || s_rdata !== model_rdata(32'h104)) begin bad++;
      $display("FAIL sim_if_resp: got rv_if=%0d rv_dm=%0d d=%h want 1 0 %h", s_rv_if, s_rv_dm, s_rdata, model_rdata(32'h104)); end
  endtask

  task automatic test_mem_wait();
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h3000; i_dm_be = 4'hF; i_dm_wdata = 32'h0;
    serve(3, 5, 1'b0, 1'b0);
    i_dm_req = 1'b0;
    total++; if (s_stable != 1 || s_timeout != 0) begin bad++; $display("FAIL wait_stable: got %0d want 1", s_stable); end
    total++; if (s_gnt_dm != 1 || s_gnt_if != 0 || s_gnt_at != 4) begin bad++;
      $display("FAIL wait_gnt: got dm=%0d if=%0d at=%0d want 1 0 4", s_gnt_dm, s_gnt_if, s_gnt_at); end
    total++; if (s_rv_dm != 1 || s_rv_if != 0 || s_rv_at != 9) begin bad++;
      $display("FAIL wait_rvalid: got dm=%0d if=%0d at=%0d want 1 0 9", s_rv_dm, s_rv_if, s_rv_at); end
    total++; if (s_rdata !== model_rdata(32'h3000)) begin bad++;
      $display("FAIL wait_rdata: got %h want %h", s_rdata, model_rdata(32'h3000)); end
  endtask

  task automatic test_gnt_rvalid_same_cycle();
    i_if_req = 1'b1; i_if_addr = 32'h200;
    serve(0, 2, 1'b1, 1'b0);
    i_if_req = 1'b0;
    total++; if (s_rv_if != 1 || s_rv_at != 3) begin bad++;
      $display("FAIL coll_rvalid: got cnt=%0d at=%0d want 1 3", s_rv_if, s_rv_at); end
    total++; if (s_rdata !== model_rdata(32'h200)) begin bad++;
      $display("FAIL coll_rdata: got %h want %h", s_rdata, model_rdata(32'h200)); end
  endtask

  task automatic test_drop_request();
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h40; i_dm_wdata = 32'h1234_5678; i_dm_be = 4'hC;
    serve(1, 1, 1'b0, 1'b1);
    i_dm_we = 1'b0;
    total++; if (s_we !== 1'b1 || s_be !== 4'hC || s_addr !== 32'h40) begin bad++;
      $display("FAIL drop_cmd: got we=%b be=%h a=%h want 1 c 40", s_we, s_be, s_addr); end
    total++; if (s_rv_dm != 1 || s_gnt_dm != 1 || s_rv_if != 0) begin bad++;
      $display("FAIL drop_resp: got rv_dm=%0d gnt_dm=%0d rv_if=%0d want 1 1 0", s_rv_dm, s_gnt_dm, s_rv_if); end
  endtask

  task automatic test_starvation();
    logic [9:0] pattern;
    logic [9:0] expect_pat;
    int         odd;
`ifdef MEM_ARB_RR_EN
    expect_pat = 10'b0101010101;
`else
    expect_pat = 10'b1111011110;
`endif
    do_reset();
    pattern = '0; odd = 0;
    i_if_req = 1'b1; i_if_addr = 32'h500;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h600; i_dm_be = 4'hF;
    for (int t = 0; t < 10; t++) begin
      serve(0, 0, 1'b0, 1'b0);
      pattern = {pattern[8:0], (s_rv_dm == 1)};
      if (s_rv_dm + s_rv_if != 1 || s_timeout != 0) odd++;
    end
    i_if_req = 1'b0; i_dm_req = 1'b0;
    total++; if (pattern !== expect_pat) begin bad++;
      $display("FAIL starve_order: got %b want %b (1=data)", pattern, expect_pat); end
    total++; if (odd != 0) begin bad++; $display("FAIL starve_single_resp: got %0d bad txns want 0", odd); end
  endtask

  task automatic test_reset_in_resp();
    int n;
    i_if_req = 1'b1; i_if_addr = 32'h700;
    n = 0;
    while (o_mem_req !== 1'b1 && n < 30) begin step(); n++; end
    total++; if (o_mem_req !== 1'b1) begin bad++; $display("FAIL rr_req: got %b want 1", o_mem_req); end
    i_mem_gnt = 1'b1;
    step(); i_mem_gnt = 1'b0; i_if_req = 1'b0; #1;
    total++; if (o_if_gnt !== 1'b1) begin bad++; $display("FAIL rr_gnt_pre: got %b want 1", o_if_gnt); end
    i_rstn = 1'b0; #1;
    total++; if ({o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_mem_req, o_mem_we} !== 6'b0 || o_mem_addr !== 32'h0) begin bad++;
      $display("FAIL rr_async: got %b addr=%h want 000000 0", {o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_mem_req, o_mem_we}, o_mem_addr); end
    step(); i_rstn = 1'b1; step();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_2222; #1;
    total++; if (o_if_rvalid !== 1'b0 || o_dm_rvalid !== 1'b0) begin bad++;
      $display("FAIL rr_stale_rvalid: got if=%b dm=%b want 0 0", o_if_rvalid, o_dm_rvalid); end
    step(); i_mem_rvalid = 1'b0; i_mem_gnt = 1'b1; #1;
    step(); i_mem_gnt = 1'b0; #1;
    total++; if (o_if_gnt !== 1'b0 || o_dm_gnt !== 1'b0 || o_mem_req !== 1'b0) begin bad++;
      $display("FAIL rr_stray_gnt: got if=%b dm=%b req=%b want 0 0 0", o_if_gnt, o_dm_gnt, o_mem_req); end
  endtask

  initial begin
    i_rstn = 1'b0; i_if_req = 1'b0; i_if_addr = '0;
    i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_be = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_mem_wait();
    test_gnt_rvalid_same_cycle();
    test_drop_request();
    test_starvation();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
